// File: rtl/line_fetch.sv
// line_fetch: fetches one video line from DDR as 4-halfword bursts (two 32-bit
// words each) into a word FIFO and streams it out as 16-bit pixels.
//   clk133_p, rst            : clock, async active-high reset
//   lineStart, lineIndex     : start fetching line lineIndex (restarts any line)
//   reqValid/reqReady/reqAddr: burst request handshake, halfword address
//   rdValid, rdData          : returned read words, upper pixel first
//   pixRead/pixValid/pixData : registered pixel stream to the consumer
//   lineDone                 : every burst of the current line has returned
// Build option: define LINE_FETCH_UNDERFLOW_EN to add the sticky 'underflow'
// output (consumer read an empty stream while the line was still in flight).
module line_fetch #(
    parameter int unsigned PIXELS_PER_LINE = 640,
    parameter int unsigned FIFO_WORDS      = 16
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        lineStart,
    input  logic [9:0]  lineIndex,
    output logic        reqValid,
    input  logic        reqReady,
    output logic [23:0] reqAddr,
    input  logic        rdValid,
    input  logic [31:0] rdData,
    input  logic        pixRead,
    output logic        pixValid,
    output logic [15:0] pixData,
`ifdef LINE_FETCH_UNDERFLOW_EN
    output logic        underflow,
`endif
    output logic        lineDone
);
    localparam int unsigned BURSTS  = PIXELS_PER_LINE / 4;
    localparam int unsigned BURST_W = $clog2(BURSTS + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_WORDS);
    localparam int unsigned CNT_W   = $clog2(FIFO_WORDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [23:0]          base_q, base_d;
    logic                 word_q, word_d;      // words of current burst received
    logic [1:0]           drain_q, drain_d;    // stale words still owed by DDR
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [15:0]          pix_data_q, pix_data_d, low_q, low_d;
    logic                 pix_valid_q, pix_valid_d, low_valid_q, low_valid_d;
    logic                 req_valid_q, req_valid_d;
    logic [23:0]          req_addr_q, req_addr_d;
    logic                 line_done_q, line_done_d;
    logic                 fifo_we, fifo_re, flush, pop;
    logic [31:0]          fifo_head;
    logic [31:0]          mem [FIFO_WORDS];

    assign fifo_head = mem[rd_ptr_q];

    // Word FIFO storage
    always_ff @(posedge clk133_p) begin
        if (fifo_we) mem[wr_ptr_q] <= rdData;
    end

    // State and datapath registers
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            burst_q     <= '0;
            base_q      <= '0;
            word_q      <= 1'b0;
            drain_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            low_q       <= '0;
            low_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            base_q      <= base_d;
            word_q      <= word_d;
            drain_q     <= drain_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            low_q       <= low_d;
            low_valid_q <= low_valid_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            line_done_q <= line_done_d;
        end
    end

    // Next-state, FIFO control and pixel output stage
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        base_d      = base_q;
        word_d      = word_q;
        drain_d     = drain_q;
        fifo_we     = 1'b0;
        fifo_re     = 1'b0;
        flush       = 1'b0;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        low_d       = low_q;
        low_valid_d = low_valid_q;
        pop         = pixRead && pix_valid_q;

        if (rdValid && drain_q != 2'd0) drain_d = drain_q - 2'd1;

        unique case (state_q)
            S_REQ: begin
                if (req_valid_q && reqReady) begin
                    state_d = S_WAIT;
                    word_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (rdValid) begin
                    fifo_we = 1'b1;
                    if (word_q) begin
                        word_d  = 1'b0;
                        burst_d = burst_q + BURST_W'(1);
                        state_d = (burst_d == BURST_W'(BURSTS)) ? S_DONE : S_REQ;
                    end else begin
                        word_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A new line overrides everything; words still owed for a burst that
        // is in flight are counted so they can be dropped on arrival.
        if (lineStart) begin
            flush   = 1'b1;
            fifo_we = 1'b0;
            if (state_q == S_WAIT)
                drain_d = 2'd2 - {1'b0, word_q} - {1'b0, rdValid};
            else if (state_q == S_REQ && req_valid_q && reqReady)
                drain_d = 2'd2;
            state_d = S_REQ;
            burst_d = '0;
            word_d  = 1'b0;
            base_d  = 24'(lineIndex) * 24'(PIXELS_PER_LINE);
        end

        // Output stage: upper half goes out first, lower half waits in low_q
        if (flush) begin
            pix_valid_d = 1'b0;
            low_valid_d = 1'b0;
        end else if (!pix_valid_q || pop) begin
            if (low_valid_q) begin
                pix_data_d  = low_q;
                pix_valid_d = 1'b1;
                low_valid_d = 1'b0;
            end else if (count_q != '0) begin
                fifo_re     = 1'b1;
                pix_data_d  = fifo_head[31:16];
                low_d       = fifo_head[15:0];
                low_valid_d = 1'b1;
                pix_valid_d = 1'b1;
            end else begin
                pix_valid_d = 1'b0;
            end
        end

        count_d = count_q;
        if (fifo_we && !fifo_re)      count_d = count_q + CNT_W'(1);
        else if (!fifo_we && fifo_re) count_d = count_q - CNT_W'(1);
        wr_ptr_d = fifo_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = fifo_re ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end

        // Request only with room for a whole burst; no writes happen in REQ,
        // so once raised the request stays stable until accepted.
        req_valid_d = (state_d == S_REQ) && (drain_d == 2'd0) &&
                      (count_d <= CNT_W'(FIFO_WORDS - 2));
        req_addr_d  = req_valid_d ? base_d + 24'({burst_d, 2'b00}) : req_addr_q;
        line_done_d = (state_d == S_DONE);
    end

    assign reqValid = req_valid_q;
    assign reqAddr  = req_addr_q;
    assign pixValid = pix_valid_q;
    assign pixData  = pix_data_q;
    assign lineDone = line_done_q;

`ifdef LINE_FETCH_UNDERFLOW_EN
    localparam int unsigned PIX_W = $clog2(PIXELS_PER_LINE);

    logic [PIX_W-1:0] pix_cnt_q;
    logic             in_line_q;
    logic             underflow_q;

    // Sticky underflow while the line still has pixels left to deliver
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            pix_cnt_q   <= '0;
            in_line_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else if (lineStart) begin
            pix_cnt_q   <= '0;
            in_line_q   <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            if (in_line_q && pixRead && !pix_valid_q) underflow_q <= 1'b1;
            if (in_line_q && pop) begin
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                if (pix_cnt_q == PIX_W'(PIXELS_PER_LINE - 1)) in_line_q <= 1'b0;
            end
        end
    end

    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_line_fetch.sv
// tb_line_fetch: randomized and directed checks of line_fetch against a
// queue-based model of the DDR side and the expected pixel stream.
module tb_line_fetch;
    localparam int unsigned PPL    = 640;
    localparam int unsigned FW     = 16;
    localparam int unsigned BURSTS = PPL / 4;

    logic        clk133_p = 1'b0;
    logic        rst;
    logic        lineStart;
    logic [9:0]  lineIndex;
    logic        reqValid;
    logic        reqReady;
    logic [23:0] reqAddr;
    logic        rdValid;
    logic [31:0] rdData;
    logic        pixRead;
    logic        pixValid;
    logic [15:0] pixData;
    logic        lineDone;
`ifdef LINE_FETCH_UNDERFLOW_EN
    logic        underflow;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk133_p = ~clk133_p;

    line_fetch #(.PIXELS_PER_LINE(PPL), .FIFO_WORDS(FW)) dut (
        .clk133_p (clk133_p),
        .rst      (rst),
        .lineStart(lineStart),
        .lineIndex(lineIndex),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqAddr  (reqAddr),
        .rdValid  (rdValid),
        .rdData   (rdData),
        .pixRead  (pixRead),
        .pixValid (pixValid),
        .pixData  (pixData),
`ifdef LINE_FETCH_UNDERFLOW_EN
        .underflow(underflow),
`endif
        .lineDone (lineDone)
    );

    task automatic step();
        @(posedge clk133_p);
        @(negedge clk133_p);
    endtask

    task automatic start_line(input logic [9:0] idx);
        rdValid   = 1'b0;
        reqReady  = 1'b0;
        pixRead   = 1'b0;
        lineStart = 1'b1;
        lineIndex = idx;
        step();
        lineStart = 1'b0;
    endtask

    // Raise reqReady until one request is accepted (bounded)
    task automatic accept_req(output logic ok, output logic [23:0] addr);
        ok = 1'b0;
        addr = '0;
        reqReady = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (reqValid) begin
                ok = 1'b1;
                addr = reqAddr;
            end
            step();
        end
        reqReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lineStart = 1'b0; lineIndex = '0; reqReady = 1'b0;
        rdValid = 1'b0; rdData = '0; pixRead = 1'b0;
        step(); step();
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL reset_reqValid got=%b exp=0", reqValid); end
        total++; if (reqAddr !== 24'h0) begin bad++; $display("FAIL reset_reqAddr got=%h exp=0", reqAddr); end
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL reset_pixValid got=%b exp=0", pixValid); end
        total++; if (pixData !== 16'h0) begin bad++; $display("FAIL reset_pixData got=%h exp=0", pixData); end
        total++; if (lineDone !== 1'b0) begin bad++; $display("FAIL reset_lineDone got=%b exp=0", lineDone); end
        rst = 1'b0;
        reqReady = 1'b1;
        step(); step(); step();
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL idle_no_request got=%b exp=0", reqValid); end
        reqReady = 1'b0;
    endtask

    // Whole line with random DDR latency/acceptance and random consumer
    task automatic test_random_line(input logic [9:0] idx);
        logic [23:0] base;
        logic [31:0] w;
        logic [15:0] e;
        logic [15:0] exp_q[$];
        int unsigned nreq, nword, pend;
        logic done;
        base = 24'(idx) * 24'(PPL);
        nreq = 0; nword = 0; pend = 0; done = 1'b0;
        start_line(idx);
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            total++; if (lineDone !== (nword == 2 * BURSTS)) begin bad++; $display("FAIL line%0d_lineDone cyc=%0d got=%b words=%0d", idx, cyc, lineDone, nword); end
            if (reqValid && pend != 0) begin total++; bad++; $display("FAIL line%0d_overlap second request while %0d words owed", idx, pend); end
            if (pixValid && exp_q.size() == 0) begin total++; bad++; $display("FAIL line%0d_phantom_pixel got=%h with nothing expected", idx, pixData); end
            reqReady = ($urandom_range(3) != 0);
            pixRead  = ($urandom_range(2) != 0);
            rdValid  = 1'b0;
            if (pend != 0 && $urandom_range(3) != 0) begin
                w = $urandom;
                rdValid = 1'b1;
                rdData = w;
                pend--;
                nword++;
                exp_q.push_back(w[31:16]);
                exp_q.push_back(w[15:0]);
            end
            if (reqValid && reqReady) begin
                total++; if (reqAddr !== base + 24'(4 * nreq)) begin bad++; $display("FAIL line%0d_addr burst=%0d got=%h exp=%h", idx, nreq, reqAddr, base + 24'(4 * nreq)); end
                nreq++;
                pend += 2;
            end
            if (pixRead && pixValid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++; if (pixData !== e) begin bad++; $display("FAIL line%0d_pixel got=%h exp=%h", idx, pixData, e); end
            end
            step();
            done = (nword == 2 * BURSTS) && (exp_q.size() == 0) && !rdValid;
        end
        rdValid = 1'b0; reqReady = 1'b0; pixRead = 1'b0;
        total++; if (!done) begin bad++; $display("FAIL line%0d_timeout words=%0d left=%0d", idx, nword, exp_q.size()); end
        total++; if (nreq !== BURSTS) begin bad++; $display("FAIL line%0d_bursts got=%0d exp=%0d", idx, nreq, BURSTS); end
        step();
        total++; if (lineDone !== 1'b1) begin bad++; $display("FAIL line%0d_done_held got=%b exp=1", idx, lineDone); end
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL line%0d_req_after_done got=%b exp=0", idx, reqValid); end
    endtask

    task automatic test_pixel_order();
        logic ok;
        logic [23:0] addr;
        start_line(10'd0);
        pixRead = 1'b1;
        accept_req(ok, addr);
        total++; if (!ok || addr !== 24'h0) begin bad++; $display("FAIL order_req ok=%b addr=%h exp=000000", ok, addr); end
        rdValid = 1'b1; rdData = 32'hAAAA5555;
        step();
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL order_latency1 pixValid got=%b exp=0", pixValid); end
        rdData = 32'h12345678;
        step();
        rdValid = 1'b0;
        total++; if (pixValid !== 1'b1 || pixData !== 16'hAAAA) begin bad++; $display("FAIL order_px0 got=%b/%h exp=1/aaaa", pixValid, pixData); end
        step();
        total++; if (pixValid !== 1'b1 || pixData !== 16'h5555) begin bad++; $display("FAIL order_px1 got=%b/%h exp=1/5555", pixValid, pixData); end
        step();
        total++; if (pixValid !== 1'b1 || pixData !== 16'h1234) begin bad++; $display("FAIL order_px2 got=%b/%h exp=1/1234", pixValid, pixData); end
        step();
        total++; if (pixValid !== 1'b1 || pixData !== 16'h5678) begin bad++; $display("FAIL order_px3 got=%b/%h exp=1/5678", pixValid, pixData); end
        step();
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL order_empty got=%b exp=0", pixValid); end
        pixRead = 1'b0;
    endtask

    // Consumer stalled: FIFO space must throttle requests
    task automatic test_backpressure();
        int unsigned nb, pend;
        start_line(10'd1);
        nb = 0; pend = 0;
        reqReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rdValid = 1'b0;
            if (pend != 0) begin
                rdValid = 1'b1;
                rdData = $urandom;
                pend--;
            end
            if (reqValid && reqReady) begin
                nb++;
                pend += 2;
            end
            step();
        end
        rdValid = 1'b0; reqReady = 1'b0;
        total++; if (nb !== (FW / 2)) begin bad++; $display("FAIL bp_bursts got=%0d exp=%0d", nb, FW / 2); end
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL bp_stalled got=%b exp=0", reqValid); end
        pixRead = 1'b1;
        step();
        total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL bp_one_pop got=%b exp=0", reqValid); end
        step();
        pixRead = 1'b0;
        total++; if (reqValid !== 1'b1) begin bad++; $display("FAIL bp_two_pops got=%b exp=1", reqValid); end
        total++; if (reqAddr !== 24'd640 + 24'd32) begin bad++; $display("FAIL bp_addr got=%h exp=%h", reqAddr, 24'd672); end
    endtask

    // New line while a burst is half returned
    task automatic test_restart();
        logic ok;
        logic [23:0] addr;
        start_line(10'd3);
        accept_req(ok, addr);
        total++; if (!ok || addr !== 24'h000780) begin bad++; $display("FAIL rs_first ok=%b addr=%h exp=000780", ok, addr); end
        rdValid = 1'b1; rdData = 32'hDEADBEEF;
        step();
        rdValid = 1'b0;
        lineStart = 1'b1; lineIndex = 10'd5; reqReady = 1'b1;
        step();
        lineStart = 1'b0;
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL rs_flush pixValid got=%b exp=0", pixValid); end
        for (int i = 0; i < 3; i++) begin
            total++; if (reqValid !== 1'b0) begin bad++; $display("FAIL rs_wait_drain cyc=%0d got=%b exp=0", i, reqValid); end
            step();
        end
        rdValid = 1'b1; rdData = 32'hBADBAD00;
        step();
        rdValid = 1'b0;
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL rs_stale_dropped pixValid got=%b exp=0", pixValid); end
        total++; if (reqValid !== 1'b1 || reqAddr !== 24'h000C80) begin bad++; $display("FAIL rs_new_req got=%b/%h exp=1/000c80", reqValid, reqAddr); end
        step();
        reqReady = 1'b0;
        rdValid = 1'b1; rdData = 32'h11112222;
        step();
        rdData = 32'h33334444;
        total++; if (pixValid !== 1'b0) begin bad++; $display("FAIL rs_latency pixValid got=%b exp=0", pixValid); end
        step();
        rdValid = 1'b0;
        total++; if (pixValid !== 1'b1 || pixData !== 16'h1111) begin bad++; $display("FAIL rs_new_data got=%b/%h exp=1/1111", pixValid, pixData); end
    endtask

    // Async reset while a request is pending
    task automatic test_reset_mid_req();
        logic ok;
        logic [23:0] addr;
        start_line(10'd7);
        accept_req(ok, addr);
        rdValid = 1'b1; rdData = $urandom;
        step();
        rdData = $urandom;
        step();
        rdValid = 1'b0;
        for (int i = 0; i < 10 && !reqValid; i++) step();
        total++; if (!ok || reqValid !== 1'b1 || pixValid !== 1'b1) begin bad++; $display("FAIL rr_setup ok=%b reqValid=%b pixValid=%b exp=1/1/1", ok, reqValid, pixValid); end
        rst = 1'b1;
        #1;
        total++; if ({reqValid, reqAddr, pixValid, pixData, lineDone} !== 42'h0) begin bad++; $display("FAIL rr_async got=%b/%h/%b/%h/%b exp=all zero", reqValid, reqAddr, pixValid, pixData, lineDone); end
        @(negedge clk133_p);
        rst = 1'b0;
        reqReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rdValid = (i < 2);
            rdData = $urandom;
            step();
            total++; if (reqValid !== 1'b0 || pixValid !== 1'b0) begin bad++; $display("FAIL rr_after_release cyc=%0d reqValid=%b pixValid=%b exp=0/0", i, reqValid, pixValid); end
        end
        rdValid = 1'b0; reqReady = 1'b0;
    endtask

`ifdef LINE_FETCH_UNDERFLOW_EN
    task automatic test_underflow();
        logic ok;
        logic [23:0] addr;
        start_line(10'd9);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear got=%b exp=0", underflow); end
        pixRead = 1'b1;
        step();
        pixRead = 1'b0;
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", underflow); end
        accept_req(ok, addr);
        rdValid = 1'b1; rdData = $urandom;
        step(); step();
        rdValid = 1'b0;
        step();
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
        start_line(10'd9);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_linestart got=%b exp=0", underflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_random_line(10'd2);
        test_pixel_order();
        test_random_line(10'($urandom_range(1023)));
        test_backpressure();
        test_restart();
        test_reset_mid_req();
`ifdef LINE_FETCH_UNDERFLOW_EN
        test_underflow();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
